// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port 16x32 memory between requesters A and B.
// Serialises accesses, waits for read valid (bounded by TIMEOUT) and returns data to the owner.
`timescale 1ns/1ps

module mem_arb_rsp #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cap_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rdata_q <= '0;
    else if (cap_i) rdata_q <= data_i;
  end

  assign rdata_o = rdata_q;
endmodule

module mem_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_reqA,
  input  logic        i_reqB,
  input  logic        i_weA,
  input  logic        i_weB,
  input  logic [3:0]  i_addrA,
  input  logic [3:0]  i_addrB,
  input  logic [31:0] i_wdataA,
  input  logic [31:0] i_wdataB,
  output logic        o_gntA,
  output logic        o_gntB,
  output logic [31:0] o_rdataA,
  output logic [31:0] o_rdataB,
  output logic        o_rvalidA,
  output logic        o_rvalidB,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_mem_EN,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_address,
  output logic [31:0] o_mem_data_in,
  input  logic [31:0] i_mem_data_out,
  input  logic        i_mem_valid
);
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  state_e               state_q, state_d;
  acc_t                 acc_q, acc_d;
  acc_t [NP-1:0]        acc_in;
  logic [NP-1:0]        req;
  logic                 own_q, own_d;     // 0 = A, 1 = B
  logic                 last_q, last_d;   // last granted, 1 = B
  logic                 win;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 rd_done, rd_tmo;
  logic [DW-1:0]        rsp_data;
  logic [NP-1:0]        cap;
  logic [NP-1:0][DW-1:0] rdata;

  assign req       = {i_reqB, i_reqA};
  assign acc_in[0] = {i_weA, i_addrA, i_wdataA};
  assign acc_in[1] = {i_weB, i_addrB, i_wdataB};

  // On a tie the requester not granted last wins; a lone request always wins.
  always_comb begin
    win = 1'b0;
    if (req[0] && req[1]) win = ~last_q;
    else                  win = ~req[0];
  end

  assign rd_done  = (state_q == WAIT) && i_mem_valid;
  assign rd_tmo   = (state_q == WAIT) && !i_mem_valid && (cnt_q == CW'(TIMEOUT - 1));
  assign rsp_data = rd_done ? i_mem_data_out : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          acc_d   = acc_in[win];
          own_d   = win;
          last_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = acc_q.we ? IDLE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        err_d = rd_tmo;
        if (rd_done || rd_tmo) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_gntA        = (state_q == ISSUE) && !own_q;
    o_gntB        = (state_q == ISSUE) &&  own_q;
    o_rvalidA     = (state_q == RESP)  && !own_q;
    o_rvalidB     = (state_q == RESP)  &&  own_q;
    o_err         = err_q;
    o_busy        = (state_q != IDLE);
    o_mem_EN      = (state_q == ISSUE);
    o_mem_we      = acc_q.we;
    o_mem_address = acc_q.addr;
    o_mem_data_in = acc_q.wdata;
  end

  // Per-requester read-data holding registers; timeout captures zero.
  for (genvar p = 0; p < NP; p++) begin : g_rsp
    assign cap[p] = (rd_done || rd_tmo) && (own_q == 1'(p));
    mem_arb_rsp #(.DW(DW)) u_rsp (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .cap_i  (cap[p]),
      .data_i (rsp_data),
      .rdata_o(rdata[p])
    );
  end

  assign o_rdataA = rdata[0];
  assign o_rdataB = rdata[1];
endmodule
